// File: rtl/fetch_controller.sv
// Fetch sequencer for a synchronous-read instruction memory: owns the PC, hides the
// one-cycle read latency behind a 2-entry {pc,data} buffer and hands words to decode.
module fetch_controller #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              halt,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_tag;
  logic [ADDR_W-1:0] r_buf_pc   [2];
  logic [DATA_W-1:0] r_buf_data [2];
  logic              r_rd_ptr;
  logic              r_wr_ptr;
  logic [1:0]        r_count;

  logic              w_pop;
  logic              w_push;
  logic              w_issue;
  logic [2:0]        w_occ;

  assign w_pop  = inst_valid & inst_ready;
  assign w_push = r_inflight;
  // Credit check: buffered plus in-flight words after this cycle's pop must leave room.
  assign w_occ   = {1'b0, r_count} + {2'b00, r_inflight};
  assign w_issue = (r_state == S_RUN) && !halt && !redirect_valid &&
                   (w_occ < (3'd2 + {2'b00, w_pop}));

  assign imem_addr  = r_pc;
  assign inst_valid = (r_count != 2'd0);
  assign inst_data  = r_buf_data[r_rd_ptr];
  assign inst_pc    = r_buf_pc[r_rd_ptr];
  assign busy       = (r_state != S_IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start && !halt && !redirect_valid) w_state_nxt = S_RUN;
      S_RUN:   if (halt) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_count == 2'd0 && !r_inflight && !redirect_valid) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pc       <= RESET_PC;
      r_inflight <= 1'b0;
      r_tag      <= '0;
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_count    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_buf_pc[i]   <= '0;
        r_buf_data[i] <= '0;
      end
    end else if (redirect_valid) begin
      // Flush: the in-flight word is dropped and the buffer forgotten.
      r_pc       <= redirect_pc;
      r_inflight <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_pc  <= r_pc + ADDR_W'(1);
        r_tag <= r_pc;
      end
      if (w_push) begin
        r_buf_pc[r_wr_ptr]   <= r_tag;
        r_buf_data[r_wr_ptr] <= imem_data;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule
